// File: rtl/minterm_scanner_if.sv
// Bundle between the minterm scanner, its controller, and the external
// N_IN-input function under scan.
interface minterm_scanner_if #(
    parameter int unsigned N_IN = 3
);
    logic                 start;
    logic                 target;
    logic [N_IN-1:0]      func_abc;
    logic                 func_y;
    logic                 busy;
    logic                 match_valid;
    logic [N_IN-1:0]      match_abc;
    logic [2**N_IN-1:0]   mask;
    logic [N_IN:0]        count;
    logic                 done;

    // Scanner side
    modport slave (
        input  start, target, func_y,
        output func_abc, busy, match_valid, match_abc, mask, count, done
    );

    // Controller / function side
    modport master (
        output start, target, func_y,
        input  func_abc, busy, match_valid, match_abc, mask, count, done
    );
endinterface

// File: rtl/minterm_scanner.sv
// Minterm scanner: sweeps every input vector through an external
// combinational function and reports the preimage of a target value
// as a mask, a population count, and a stream of matching vectors.
module minterm_scanner #(
    parameter int unsigned N_IN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    minterm_scanner_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] LAST_VEC = '1;

    state_t state;
    state_t state_nxt;
    logic   target_q;
    logic   last_vec;
    logic   hit;

    assign last_vec = (bus.func_abc == LAST_VEC);
    assign hit      = (bus.func_y == target_q);

    assign bus.busy = (state == SCAN);
    assign bus.done = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = SCAN;
            SCAN:    if (last_vec)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Vector sweep, result accumulation and match streaming
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q        <= 1'b0;
            bus.func_abc    <= '0;
            bus.match_valid <= 1'b0;
            bus.match_abc   <= '0;
            bus.mask        <= '0;
            bus.count       <= '0;
        end else begin
            bus.match_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        target_q     <= bus.target;
                        bus.func_abc <= '0;
                        bus.mask     <= '0;
                        bus.count    <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        bus.mask[bus.func_abc] <= 1'b1;
                        bus.count              <= bus.count + 1'b1;
                        bus.match_valid        <= 1'b1;
                        bus.match_abc          <= bus.func_abc;
                    end
                    // Sweep stops on the all-ones vector; it stays there while idle
                    if (!last_vec) begin
                        bus.func_abc <= bus.func_abc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_scanner.sv
// Self-checking bench for minterm_scanner (N_IN=3) driving a truth-table
// function model and comparing against a preimage reference.
module tb_minterm_scanner;

    localparam int unsigned N = 3;
    localparam int unsigned V = 2**N;

    logic clk;
    logic rst_n;
    logic [V-1:0] tt;

    int total;
    int bad;

    // observations collected by capture()
    int unsigned obs_vec[$];
    int unsigned obs_cyc[$];
    int          done_n;
    int          done_cyc;
    int          busy_n;
    logic [V-1:0] mask_done;
    logic [N:0]   count_done;

    minterm_scanner_if #(.N_IN(N)) bus ();

    minterm_scanner #(.N_IN(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // External function: truth table indexed by the driven vector
    assign bus.func_y = tt[bus.func_abc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Start one scan and record what the DUT shows each cycle after accept.
    // Cycle c is the cycle following accept edge c-1.
    task automatic capture(input bit tgt, input bit disturb);
        obs_vec.delete();
        obs_cyc.delete();
        done_n = 0; done_cyc = -1; busy_n = 0;
        mask_done = '0; count_done = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.target = tgt;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (bus.match_valid) begin
                obs_vec.push_back(int'(bus.match_abc));
                obs_cyc.push_back(c);
            end
            if (bus.done) begin
                done_n++; done_cyc = c;
                mask_done = bus.mask; count_done = bus.count;
            end
            if (bus.busy) busy_n++;
            if (disturb) begin
                bus.start  = (c == 3 || c == 6);
                bus.target = ~bus.target;
            end
            @(negedge clk);
        end
        bus.start = 1'b0; bus.target = tgt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.target = 1'b0; tt = '0;
        #12;
        total++;
        if (bus.func_abc !== '0 || bus.match_abc !== '0 || bus.mask !== '0 ||
            bus.count !== '0 || bus.busy !== 1'b0 || bus.match_valid !== 1'b0 ||
            bus.done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got abc=%h mabc=%h mask=%h cnt=%0d busy=%b mv=%b done=%b exp all 0",
                     bus.func_abc, bus.match_abc, bus.mask, bus.count, bus.busy, bus.match_valid, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_function_scan(input string name, input logic [V-1:0] f,
                                      input bit tgt, input bit disturb);
        int unsigned  exp_q[$];
        logic [V-1:0] m_e;
        logic [N:0]   c_e;
        tt = f; m_e = '0; c_e = '0;
        for (int k = 0; k < int'(V); k++) begin
            if (f[k] == tgt) begin
                exp_q.push_back(k);
                m_e[k] = 1'b1;
                c_e = c_e + 1'b1;
            end
        end
        capture(tgt, disturb);

        total++;
        if (done_n != 1 || done_cyc != int'(V) + 1) begin
            bad++;
            $display("FAIL %s done got n=%0d cyc=%0d exp n=1 cyc=%0d", name, done_n, done_cyc, V + 1);
        end
        total++;
        if (busy_n != int'(V)) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, busy_n, V);
        end
        total++;
        if (mask_done !== m_e || count_done !== c_e) begin
            bad++;
            $display("FAIL %s result_at_done got mask=%h cnt=%0d exp mask=%h cnt=%0d",
                     name, mask_done, count_done, m_e, c_e);
        end
        total++;
        if (bus.mask !== m_e || bus.count !== c_e || bus.func_abc !== {N{1'b1}}) begin
            bad++;
            $display("FAIL %s idle_hold got mask=%h cnt=%0d abc=%h exp mask=%h cnt=%0d abc=%h",
                     name, bus.mask, bus.count, bus.func_abc, m_e, c_e, {N{1'b1}});
        end
        total++;
        if (obs_vec.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s match_pulses got=%0d exp=%0d", name, obs_vec.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                total++;
                if (obs_vec[i] != exp_q[i] || obs_cyc[i] != exp_q[i] + 2) begin
                    bad++;
                    $display("FAIL %s match[%0d] got vec=%0d cyc=%0d exp vec=%0d cyc=%0d",
                             name, i, obs_vec[i], obs_cyc[i], exp_q[i], exp_q[i] + 2);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int i;
        tt = 8'($urandom);
        @(negedge clk);
        bus.start = 1'b1; bus.target = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        i = 0;
        while (i < 20 && bus.func_abc != 3'd4) begin
            @(negedge clk);
            i++;
        end
        total++;
        if (bus.func_abc !== 3'd4 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL async_reset_reach_v4 got abc=%h busy=%b exp abc=4 busy=1", bus.func_abc, bus.busy);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.func_abc !== '0 || bus.match_abc !== '0 || bus.mask !== '0 ||
            bus.count !== '0 || bus.busy !== 1'b0 || bus.match_valid !== 1'b0 ||
            bus.done !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_clear got abc=%h mabc=%h mask=%h cnt=%0d busy=%b mv=%b done=%b exp all 0",
                     bus.func_abc, bus.match_abc, bus.mask, bus.count, bus.busy, bus.match_valid, bus.done);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.func_abc !== '0) begin
            bad++;
            $display("FAIL async_reset_idle got busy=%b abc=%h exp busy=0 abc=0", bus.busy, bus.func_abc);
        end
    endtask

    task automatic test_back_to_back();
        logic [V-1:0] m_e;
        logic [N:0]   c_e;
        bit           tgt;
        int           dones[$];
        int           low_run;
        int           rises;
        bit           seen_high;
        tt  = 8'($urandom);
        tgt = 1'($urandom);
        m_e = '0; c_e = '0;
        for (int k = 0; k < int'(V); k++) begin
            if (tt[k] == tgt) begin
                m_e[k] = 1'b1;
                c_e = c_e + 1'b1;
            end
        end
        low_run = 0; rises = 0; seen_high = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.target = tgt;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.done) begin
                dones.push_back(c);
                total++;
                if (bus.mask !== m_e || bus.count !== c_e) begin
                    bad++;
                    $display("FAIL b2b_result cyc=%0d got mask=%h cnt=%0d exp mask=%h cnt=%0d",
                             c, bus.mask, bus.count, m_e, c_e);
                end
            end
            if (bus.busy) begin
                if (seen_high && low_run > 0) begin
                    rises++;
                    total++;
                    if (low_run != 2) begin
                        bad++;
                        $display("FAIL b2b_busy_gap got=%0d exp=2", low_run);
                    end
                end
                seen_high = 1; low_run = 0;
            end else begin
                low_run++;
            end
        end
        bus.start = 1'b0;
        total++;
        if (dones.size() != 3 || rises != 2) begin
            bad++;
            $display("FAIL b2b_scan_count got dones=%0d gaps=%0d exp dones=3 gaps=2", dones.size(), rises);
        end else begin
            total++;
            if (dones[0] != int'(V) + 1 || dones[1] - dones[0] != int'(V) + 2 || dones[2] - dones[1] != int'(V) + 2) begin
                bad++;
                $display("FAIL b2b_spacing got %0d,%0d,%0d exp 9,19,29", dones[0], dones[1], dones[2]);
            end
        end
        repeat (12) @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_function_scan("team_t1", 8'h17, 1'b1, 1'b0);
        test_function_scan("team_t0", 8'h17, 1'b0, 1'b0);
        test_function_scan("const1_t1", 8'hFF, 1'b1, 1'b0);
        test_function_scan("const1_t0", 8'hFF, 1'b0, 1'b0);
        test_function_scan("team_disturbed", 8'h17, 1'b1, 1'b1);
        test_async_reset();
        test_function_scan("after_reset", 8'h17, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            test_function_scan("random", 8'($urandom), 1'($urandom), 1'($urandom));
        end
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
